mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter and sequencer in front of the memory-map slave port (RAM/UART decode).
- Master 0 is the pipeline MEM stage (core load/store). Master 1 is the UART boot-loader / debug writer.
- Serialises accesses, inserts wait states for slow slaves and raises a pipeline stall while the core's access is outstanding.
- Round-robin fairness, with a timeout so a dead slave cannot hang the core.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 15, maximum cycles waiting for s_ready before an error completion (>=1, counter width $clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  core access request; held until m0_ack.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  ADDR_WIDTH  core address.
- m0_wdata  in  DATA_WIDTH  core store data.
- m0_rdata  out  DATA_WIDTH  read data, valid while m0_ack=1.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as m0_*, for the loader.
- s_sel  out  1  slave access strobe (held for the whole access).
- s_we  out  1  slave write enable (qualified by s_sel).
- s_addr  out  ADDR_WIDTH  slave address.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_rdata  in  DATA_WIDTH  slave read data, sampled when s_ready=1.
- s_ready  in  1  slave completion.
- stall_o  out  1  core stall = m0_req & ~m0_ack (combinational).
- err_o  out  1  one-cycle pulse on timeout completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM to IDLE, last_grant=1 (so m0 wins the first tie).
  - All outputs 0: s_*, m*_ack, m*_rdata, err_o.
  - Any in-flight access is abandoned with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req, pick a winner: the sole requester, or on a tie the master that is not last_grant.
  - Register winner id, we, addr and wdata onto s_*; set s_sel=1; go to ACCESS. Clear the timeout counter.
  - No req: stay in IDLE.
- ACCESS:
  - s_sel and s_* held constant.
  - s_ready=1: capture s_rdata (writes capture 0); drop s_sel; go to DONE.
  - Otherwise increment the counter. When the counter == TIMEOUT with no s_ready: capture 0, set the error flag, drop s_sel, go to DONE.
  - Request inputs are ignored while in ACCESS; a mid-access change is not seen.
- DONE:
  - Pulse the winner's m*_ack for exactly one cycle, with m*_rdata valid that cycle.
  - err_o pulses in the same cycle if the timeout flag is set.
  - last_grant <= winner; go to IDLE.
  - Losing master's ack stays 0. m*_rdata holds its last value otherwise.
- Latency:
  - Request seen at edge N: s_sel=1 after edge N.
  - s_ready seen at edge N+k: ack high during cycle N+k+1.
  - Minimum, a zero-wait slave with s_ready combinational in the first ACCESS cycle: ack in cycle N+2.
  - Back-to-back: next grant at the edge after DONE, so throughput is at most one access per 3 cycles.
- Requesters must hold req and fields stable until ack.
  - Dropping req before ack: the access still completes and the ack still pulses. The requester ignores it.
- Simultaneous continuous requests alternate m0, m1, m0, ...
  - No starvation: each master waits at most one foreign access.
- stall_o is high in every cycle where m0 is pending, including while m1 holds the bus. It is low in the m0_ack cycle so the pipeline advances.
- s_ready outside ACCESS is ignored.

Decomposition:
- Package riscv_bus_pkg holds:
  - the state encoding (IDLE/ACCESS/DONE);
  - master id constants MST_CORE=0, MST_LOADER=1;
  - the default TIMEOUT.
- One natural sub-module, rr_arbiter_2: combinational 2-way round-robin pick (req[1:0], last_grant -> grant id, grant_valid). It is reusable for later multi-master expansion.

Test Plan:
- Reset mid-ACCESS: m0 read to 0x100, assert rst in the 2nd ACCESS cycle -> s_sel=0 next cycle, no m0_ack, FSM IDLE; after release m0 re-granted first.
- Single core read, zero-wait slave: m0_addr=0x10, s_rdata=0xDEADBEEF with s_ready in the first ACCESS cycle -> m0_ack in cycle N+2 with m0_rdata=0xDEADBEEF; stall_o=1 for cycles N..N+1, 0 in N+2.
- Write with 3 wait states: m1_we=1, addr=0x20, wdata=0x0000_00A5, s_ready on the 4th ACCESS cycle -> s_sel/s_we/s_wdata stable for 4 cycles, m1_ack one cycle later, m0_ack=0.
- Contention: m0 and m1 both request continuously from reset -> grant order m0, m1, m0, m1; each ack a single cycle; stall_o high while m1 is served.
- Timeout: s_ready tied 0, m0 read -> after TIMEOUT=15 ACCESS cycles, m0_ack=1, m0_rdata=0, err_o=1 for one cycle; next request is serviced normally.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared encodings for the memory-bus arbiter: FSM states, master ids and
// the default slave timeout.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  localparam logic MST_CORE   = 1'b0;
  localparam logic MST_LOADER = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: a sole requester wins outright,
// a tie goes to whichever master was not granted last.
module rr_arbiter_2
  import riscv_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_grant_valid
);

  always_comb begin
    o_grant_valid = |i_req;
    if (&i_req) begin
      o_grant = ~i_last_grant;
    end else if (i_req[MST_LOADER]) begin
      o_grant = MST_LOADER;
    end else begin
      o_grant = MST_CORE;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and sequencer in front of the memory-map slave port.
// Serialises accesses, waits on s_ready with a timeout, stalls the core.
module mem_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ack,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ack,
  output logic                  s_sel,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ready,
  output logic                  stall_o,
  output logic                  err_o
);

  // state  | meaning
  // IDLE   | bus free; arbitrate and launch on the next edge
  // ACCESS | s_sel and s_* held; wait for s_ready or timeout
  // DONE   | winner's ack (and err on timeout) pulse; update last_grant

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  bus_state_t r_state, w_state_nxt;

  logic [1:0]            w_req;
  logic                  w_grant;
  logic                  w_grant_valid;
  logic                  w_cnt_tc;
  logic                  w_access_end;
  logic [DATA_WIDTH-1:0] w_capture;

  logic                  r_last_grant;
  logic                  r_winner;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_s_sel;
  logic                  r_s_we;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wdata;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_m0_ack;
  logic                  r_m1_ack;
  logic                  r_err;

  assign w_req = {m1_req, m0_req};

  rr_arbiter_2 u_rr (
    .i_req         (w_req),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // Down-counter loaded with TIMEOUT-1 gives exactly TIMEOUT ACCESS cycles.
  assign w_cnt_tc     = (r_cnt == '0);
  assign w_access_end = s_ready | w_cnt_tc;
  assign w_capture    = (s_ready && !r_s_we) ? s_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_access_end)  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= MST_LOADER;
      r_winner     <= MST_CORE;
      r_cnt        <= '0;
      r_s_sel      <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_winner  <= w_grant;
            r_s_sel   <= 1'b1;
            r_s_we    <= (w_grant == MST_LOADER) ? m1_we    : m0_we;
            r_s_addr  <= (w_grant == MST_LOADER) ? m1_addr  : m0_addr;
            r_s_wdata <= (w_grant == MST_LOADER) ? m1_wdata : m0_wdata;
            r_cnt     <= CNT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (w_access_end) begin
            r_s_sel <= 1'b0;
            r_err   <= ~s_ready;
            if (r_winner == MST_LOADER) begin
              r_m1_rdata <= w_capture;
              r_m1_ack   <= 1'b1;
            end else begin
              r_m0_rdata <= w_capture;
              r_m0_ack   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: r_last_grant <= r_winner;
        default: ;
      endcase
    end
  end

  assign s_sel    = r_s_sel;
  assign s_we     = r_s_we;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign err_o    = r_err;
  assign stall_o  = m0_req & ~r_m0_ack;

endmodule
